// File: rtl/android2fpga_st_bytes_to_packets.sv
// rtl/android2fpga_st_bytes_to_packets.sv - in-band framed byte stream to SOP/EOP/channel packet stream decoder
module android2fpga_st_bytes_to_packets #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     in_ready_o,
    input  logic                     in_valid_i,
    input  logic [7:0]               in_data_i,
    input  logic                     out_ready_i,
    output logic                     out_valid_o,
    output logic [7:0]               out_data_o,
    output logic                     out_startofpacket_o,
    output logic                     out_endofpacket_o,
    output logic [CHANNEL_WIDTH-1:0] out_channel_o
);

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    // Framing flags collected ahead of the next data byte
    logic pending_sop_q, pending_sop_d;
    logic pending_eop_q, pending_eop_d;
    logic expect_chan_q, expect_chan_d;
    logic escaped_q, escaped_d;
    logic [CHANNEL_WIDTH-1:0] channel_q, channel_d;

    // One-entry output register
    logic                     out_valid_q, out_valid_d;
    logic [7:0]               out_data_q, out_data_d;
    logic                     out_sop_q, out_sop_d;
    logic                     out_eop_q, out_eop_d;
    logic [CHANNEL_WIDTH-1:0] out_channel_q, out_channel_d;

    logic       accept;
    logic [7:0] byte_val;

    // The output register can take a new beat whenever it is empty or being drained
    assign in_ready_o = out_ready_i || !out_valid_q;

    assign out_valid_o         = out_valid_q;
    assign out_data_o          = out_data_q;
    assign out_startofpacket_o = out_sop_q;
    assign out_endofpacket_o   = out_eop_q;
    assign out_channel_o       = out_channel_q;

    // Decode the accepted byte into flag updates, a channel capture or a data beat
    always_comb begin
        pending_sop_d = pending_sop_q;
        pending_eop_d = pending_eop_q;
        expect_chan_d = expect_chan_q;
        escaped_d     = escaped_q;
        channel_d     = channel_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_channel_d = out_channel_q;

        accept   = in_valid_i && in_ready_o;
        byte_val = escaped_q ? (in_data_i ^ ESC_XOR) : in_data_i;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (!escaped_q && in_data_i == SOP_CHAR) begin
                pending_sop_d = 1'b1;
                expect_chan_d = 1'b0;
            end else if (!escaped_q && in_data_i == EOP_CHAR) begin
                pending_eop_d = 1'b1;
                expect_chan_d = 1'b0;
            end else if (!escaped_q && in_data_i == CHAN_CHAR) begin
                expect_chan_d = 1'b1;
            end else if (!escaped_q && in_data_i == ESC_CHAR) begin
                // expect_chan is deliberately left alone so an escaped channel byte works
                escaped_d = 1'b1;
            end else begin
                escaped_d = 1'b0;
                if (expect_chan_q) begin
                    channel_d     = byte_val[CHANNEL_WIDTH-1:0];
                    expect_chan_d = 1'b0;
                end else begin
                    out_valid_d   = 1'b1;
                    out_data_d    = byte_val;
                    out_sop_d     = pending_sop_q;
                    out_eop_d     = pending_eop_q;
                    out_channel_d = channel_q;
                    pending_sop_d = 1'b0;
                    pending_eop_d = 1'b0;
                end
            end
        end
    end

    // State register; reset drops any partially decoded packet immediately
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_sop_q <= 1'b0;
            pending_eop_q <= 1'b0;
            expect_chan_q <= 1'b0;
            escaped_q     <= 1'b0;
            channel_q     <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'h00;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_channel_q <= '0;
        end else begin
            pending_sop_q <= pending_sop_d;
            pending_eop_q <= pending_eop_d;
            expect_chan_q <= expect_chan_d;
            escaped_q     <= escaped_d;
            channel_q     <= channel_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_channel_q <= out_channel_d;
        end
    end

endmodule

// File: tb/tb_android2fpga_st_bytes_to_packets.sv
// tb/tb_android2fpga_st_bytes_to_packets.sv - scoreboard bench for the byte-to-packet decoder
module tb_android2fpga_st_bytes_to_packets;

    localparam int CW = 8;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          in_ready_o;
    logic          in_valid_i;
    logic [7:0]    in_data_i;
    logic          out_ready_i;
    logic          out_valid_o;
    logic [7:0]    out_data_o;
    logic          out_startofpacket_o;
    logic          out_endofpacket_o;
    logic [CW-1:0] out_channel_o;

    android2fpga_st_bytes_to_packets #(.CHANNEL_WIDTH(CW)) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .in_ready_o          (in_ready_o),
        .in_valid_i          (in_valid_i),
        .in_data_i           (in_data_i),
        .out_ready_i         (out_ready_i),
        .out_valid_o         (out_valid_o),
        .out_data_o          (out_data_o),
        .out_startofpacket_o (out_startofpacket_o),
        .out_endofpacket_o   (out_endofpacket_o),
        .out_channel_o       (out_channel_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0]    d;
        logic          sop;
        logic          eop;
        logic [CW-1:0] ch;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_beats  = 0;
    int    rdy_mode = 0;
    bit    beat_due = 0;
    bit    mon_en   = 0;

    // Reference model state: what has been announced since the last data byte
    bit      m_sop, m_eop, m_want_chan, m_esc;
    logic [CW-1:0] m_chan;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_sop = 0; m_eop = 0; m_want_chan = 0; m_esc = 0; m_chan = '0;
    endfunction

    // Returns 1 when the byte becomes an output beat
    function automatic bit model_byte(input logic [7:0] raw);
        bit         special;
        logic [7:0] v;
        beat_t      b;
        special = !m_esc && (raw >= 8'h7A) && (raw <= 8'h7D);
        v       = m_esc ? (raw ^ 8'h20) : raw;
        if (special) begin
            case (raw)
                8'h7A:   begin m_sop = 1; m_want_chan = 0; end
                8'h7B:   begin m_eop = 1; m_want_chan = 0; end
                8'h7C:   m_want_chan = 1;
                default: m_esc = 1;
            endcase
            return 0;
        end
        m_esc = 0;
        if (m_want_chan) begin
            m_chan      = v[CW-1:0];
            m_want_chan = 0;
            return 0;
        end
        b.d = v; b.sop = m_sop; b.eop = m_eop; b.ch = m_chan;
        exp_q.push_back(b);
        m_sop = 0; m_eop = 0;
        return 1;
    endfunction

    // A data byte accepted on the last edge must be visible one cycle later
    task automatic latency_check();
        if (beat_due) begin
            check("latency_out_valid", {31'd0, out_valid_o}, 32'd1);
            beat_due = 0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int waited = 0;
        bit done   = 0;
        while (!done) begin
            @(negedge clk_i);
            out_ready_i = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid_i  = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
            in_data_i   = b;
            #1;
            latency_check();
            if (in_valid_i && in_ready_o) begin
                done     = 1;
                beat_due = model_byte(b);
            end else if (++waited > 200) begin
                check("send_timeout", 32'd1, 32'd0);
                done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            in_valid_i  = 1'b0;
            out_ready_i = 1'b1;
            #1;
            latency_check();
        end
    endtask

    // Monitor: pops the scoreboard on every delivered beat and checks stall behaviour
    beat_t held;
    bit    was_stalled = 0;
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            if (mon_en && !reset_i) begin
                check("in_ready_eq", {31'd0, in_ready_o}, {31'd0, out_ready_i || !out_valid_o});
                if (was_stalled) begin
                    check("stall_hold", {out_valid_o, out_data_o, out_startofpacket_o, out_endofpacket_o, out_channel_o},
                          {1'b1, held});
                end
                if (out_valid_o && out_ready_i) begin
                    n_beats++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {out_data_o, out_channel_o}, 32'hFFFF);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("beat", {out_data_o, out_startofpacket_o, out_endofpacket_o, out_channel_o}, e);
                    end
                end
                was_stalled = out_valid_o && !out_ready_i;
                held        = {out_data_o, out_startofpacket_o, out_endofpacket_o, out_channel_o};
            end else begin
                was_stalled = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] t1[7] = '{8'h7A, 8'h7C, 8'h03, 8'h11, 8'h22, 8'h7B, 8'h33};
    logic [7:0] t2[6] = '{8'h7A, 8'h7D, 8'h5A, 8'h7B, 8'h7D, 8'h5D};
    logic [7:0] t3[3] = '{8'h7A, 8'h7B, 8'h44};
    logic [7:0] t5[7] = '{8'h7C, 8'h7B, 8'h55, 8'h7C, 8'h7D, 8'h5C, 8'h66};

    initial begin
        reset_i     = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = 8'h00;
        out_ready_i = 1'b0;
        model_reset();
        #1;
        check("reset_outputs", {out_valid_o, out_data_o, out_startofpacket_o, out_endofpacket_o, out_channel_o}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        mon_en  = 1;

        rdy_mode = 0;
        foreach (t1[i]) send(t1[i]);
        foreach (t2[i]) send(t2[i]);
        foreach (t3[i]) send(t3[i]);
        idle(2);

        // Back-pressure: beat 0x11 pending, sink stalls while more bytes are offered
        send(8'h7A);
        send(8'h11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            out_ready_i = 1'b0;
            in_valid_i  = 1'b1;
            in_data_i   = 8'h22;
            #1;
            latency_check();
            check("stall_in_ready", {31'd0, in_ready_o}, 32'd0);
            check("stall_data", {24'd0, out_data_o}, 32'h11);
        end
        send(8'h22);
        send(8'h7B);
        send(8'h33);
        foreach (t5[i]) send(t5[i]);
        idle(3);
        check("drain_directed", exp_q.size(), 32'd0);

        // Reset mid-sequence discards SOP and channel expectation
        send(8'h7A);
        send(8'h7C);
        idle(1);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        check("midreset_outputs", {out_valid_o, out_data_o, out_startofpacket_o, out_endofpacket_o, out_channel_o}, 32'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk_i);
        reset_i = 1'b0;
        send(8'h77);
        idle(3);

        // Random traffic biased toward framing characters, random valid/ready
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 2) == 0) ? (8'h7A + 8'($urandom_range(0, 3))) : 8'($urandom);
            send(b);
        end
        idle(5);
        check("drain_random", exp_q.size(), 32'd0);
        check("beats_seen", {31'd0, n_beats > 100}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
